wdt_reset_sequencer: RTL and testbench
======================================

// Module: wdt_reset_sequencer
// PURPOSE
// - Sequences board reset from watchdog timeouts and software requests; sits between watchdog and board reset pin.
// - Stretches each reset to a programmable number of slow ticks, then enforces a blanking window.
// - Counts back-to-back watchdog resets and switches the boot source to failsafe after a limit.
// - CSR-mapped on the shared 8-bit CSR bus; ticks on the same slow clock enable as the watchdog.
// PARAMETERS
// - BASE_ADDR    5'h4  CSR base address; block decodes BASE_ADDR+0..+2
// - DFL_HOLD     8'h8  reset value of HOLD register (slow ticks reset stays asserted)
// - BLANK_TICKS  4     slow ticks after release during which new requests are ignored
// - MAX_RETRIES  3     consecutive watchdog resets before failsafe latches
// PORTS
// - clk          in   1  system clock
// - rst          in   1  synchronous active-high reset
// - csr_a        in   5  CSR address
// - csr_di       in   8  CSR write data
// - csr_we       in   1  CSR write strobe, one clk per write
// - csr_do       out  8  CSR read data; 8'h00 when csr_a outside block range
// - tick_ce      in   1  slow clock enable, one clk wide
// - wdt_timeout  in   1  watchdog expiry pulse, one clk wide
// - boot_done    in   1  level, high once software signals a good boot
// - board_rst    out  1  active-high board reset request
// - failsafe     out  1  selects failsafe boot source
// BEHAVIOUR
// - Registers: +0 CTRL (W: bit0 soft reset request, bit1 clear CAUSE, bit2 clear failsafe+retry; reads 0)
//   +1 STATUS (R: [1:0] cause 00 none/01 wdt/10 soft, [3:2] retry count, bit4 failsafe, bit7 busy)
//   +2 HOLD (R/W, 8 bit; 0 treated as 1)
// - csr_do combinational from csr_a; writes take effect on the clk where csr_we=1.
// - After rst: state IDLE, board_rst=0, failsafe=0, cause=00, retries=0, HOLD=DFL_HOLD, csr_do per decode.
// - FSM IDLE: on wdt_timeout or soft-reset write -> ASSERT next clk; load hold counter with max(HOLD,1);
//   latch cause (wdt wins if both same clk); wdt source increments retries (saturating).
// - ASSERT: board_rst=1; counter decrements on tick_ce; leaves when counter hits 0 -> BLANK;
//   board_rst drops on first clk of BLANK. Assertion length = HOLD ticks, +/-1 tick phase.
// - BLANK: board_rst=0; counts BLANK_TICKS ticks, then -> IDLE. Requests in ASSERT/BLANK ignored
//   (neither cause nor retries change).
// - busy = (state != IDLE).
// - retries reaching MAX_RETRIES sets failsafe (sticky) on the same clk as entering ASSERT.
// - boot_done=1 in IDLE clears retries (not failsafe) each clk.
// - failsafe cleared only by rst or CTRL bit2; bit2 also zeroes retries.
// - CAUSE cleared by CTRL bit1 unless same-clk new request (new cause wins).
// - HOLD write during ASSERT does not affect running count; applies next sequence.
// - rst mid-sequence returns to IDLE with board_rst=0 on the next clk.
// STRUCTURE
// - Shared package/include: CSR offsets (CTRL/STATUS/HOLD), cause encodings, FSM state encoding.
// - One sub-module natural: tick_counter (loadable down counter on tick_ce, zero flag), used for hold and blank.
// - CSR decode, FSM and retry/failsafe logic stay in the top module.
// TESTING
// - Reset, read +1 -> 8'h00; read +2 -> DFL_HOLD; read address BASE_ADDR+3 -> 8'h00.
// - HOLD=4, wdt_timeout pulse -> board_rst high 4 ticks (+/-1), STATUS cause=01, retries=1, busy until BLANK ends.
// - Write CTRL=8'h01 -> board_rst asserted, cause=10, retries unchanged; second write during ASSERT ignored.
// - Three wdt sequences, boot_done=0 -> failsafe=1 entering third ASSERT; CTRL=8'h04 -> failsafe=0, retries=0.
// - wdt_timeout and soft write same clk -> cause=01; wdt pulse during BLANK -> no new sequence.
// - rst asserted mid-ASSERT -> board_rst=0 next clk, STATUS=8'h00, HOLD back to DFL_HOLD.

Source files
------------

// File: rtl/wdt_reset_sequencer_pkg.sv
// Shared definitions for the watchdog reset sequencer:
// CSR offsets, cause codes, FSM states and the hold-count helper.
package wdt_reset_sequencer_pkg;

    localparam logic [4:0] OFF_CTRL   = 5'd0;
    localparam logic [4:0] OFF_STATUS = 5'd1;
    localparam logic [4:0] OFF_HOLD   = 5'd2;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_WDT  = 2'b01,
        CAUSE_SOFT = 2'b10
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_BLANK  = 2'd2
    } state_e;

    // A programmed hold of zero still gives a one-tick reset.
    function automatic logic [7:0] hold_eff(input logic [7:0] h);
        return (h == 8'd0) ? 8'd1 : h;
    endfunction

endpackage

// File: rtl/wdt_reset_sequencer_if.sv
// CSR bus plus watchdog/board-reset signals of the reset sequencer.
interface wdt_reset_sequencer_if;

    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;
    logic       tick_ce;
    logic       wdt_timeout;
    logic       boot_done;
    logic       board_rst;
    logic       failsafe;

    modport master (
        output csr_a, csr_di, csr_we, tick_ce, wdt_timeout, boot_done,
        input  csr_do, board_rst, failsafe
    );

    modport slave (
        input  csr_a, csr_di, csr_we, tick_ce, wdt_timeout, boot_done,
        output csr_do, board_rst, failsafe
    );

endinterface

// File: rtl/wdt_reset_sequencer_tick_counter.sv
// Loadable down counter stepping on the slow tick enable.
// Holds at zero; load has priority over a same-clk tick.
module wdt_reset_sequencer_tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wdt_reset_sequencer.sv
// Board reset sequencer: stretches watchdog/soft resets, blanks
// re-triggers and latches failsafe boot after repeated wdt resets.
module wdt_reset_sequencer
    import wdt_reset_sequencer_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR   = 5'h4,
    parameter logic [7:0] DFL_HOLD    = 8'h8,
    parameter int         BLANK_TICKS = 4,
    parameter int         MAX_RETRIES = 3
) (
    input logic                  clk,
    input logic                  rst,
    wdt_reset_sequencer_if.slave bus
);

    state_e     state_q, state_d;
    cause_e     cause_q, cause_d;
    logic [1:0] retry_q, retry_d;
    logic       fs_q, fs_d;
    logic [7:0] hold_q, hold_d;

    logic       cnt_load;
    logic [7:0] cnt_val;
    logic       cnt_zero;

    logic wr_ctrl, wr_hold, idle, req_wdt, req_soft, start;

    assign wr_ctrl  = bus.csr_we && (bus.csr_a == BASE_ADDR + OFF_CTRL);
    assign wr_hold  = bus.csr_we && (bus.csr_a == BASE_ADDR + OFF_HOLD);
    assign idle     = (state_q == ST_IDLE);
    assign req_wdt  = idle && bus.wdt_timeout;
    assign req_soft = idle && wr_ctrl && bus.csr_di[0];
    assign start    = req_wdt || req_soft;

    wdt_reset_sequencer_tick_counter #(
        .W (8)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .tick_i     (bus.tick_ce),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = hold_eff(hold_q);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_ASSERT;
                    cnt_load = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (cnt_zero) begin
                    state_d  = ST_BLANK;
                    cnt_load = 1'b1;
                    cnt_val  = 8'(BLANK_TICKS);
                end
            end
            ST_BLANK: begin
                if (cnt_zero) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cause_d = cause_q;
        retry_d = retry_q;
        fs_d    = fs_q;
        hold_d  = wr_hold ? bus.csr_di : hold_q;
        if (wr_ctrl && bus.csr_di[1]) cause_d = CAUSE_NONE;
        if (req_wdt) begin
            cause_d = CAUSE_WDT;
        end else if (req_soft) begin
            cause_d = CAUSE_SOFT;
        end
        // Software clear beats a same-clk retry update.
        if (wr_ctrl && bus.csr_di[2]) begin
            retry_d = 2'd0;
            fs_d    = 1'b0;
        end else if (req_wdt) begin
            retry_d = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
            if (int'(retry_d) >= MAX_RETRIES) fs_d = 1'b1;
        end else if (idle && bus.boot_done) begin
            retry_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            retry_q <= 2'd0;
            fs_q    <= 1'b0;
            hold_q  <= DFL_HOLD;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            retry_q <= retry_d;
            fs_q    <= fs_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        bus.csr_do = 8'h00;
        unique case (1'b1)
            (bus.csr_a == BASE_ADDR + OFF_STATUS):
                bus.csr_do = {!idle, 2'b00, fs_q, retry_q, cause_q};
            (bus.csr_a == BASE_ADDR + OFF_HOLD):
                bus.csr_do = hold_q;
            default:
                bus.csr_do = 8'h00;
        endcase
    end

    assign bus.board_rst = (state_q == ST_ASSERT);
    assign bus.failsafe  = fs_q;

endmodule

// File: tb/tb_wdt_reset_sequencer.sv
// Directed + randomized bench for wdt_reset_sequencer with a
// register-level reference model of cause/retry/failsafe/hold.
module tb_wdt_reset_sequencer;

    localparam logic [4:0] BASE  = 5'h4;
    localparam int         BLANK = 4;
    localparam int         MAXR  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wdt_reset_sequencer_if bus ();

    wdt_reset_sequencer #(
        .BASE_ADDR   (BASE),
        .DFL_HOLD    (8'h08),
        .BLANK_TICKS (BLANK),
        .MAX_RETRIES (MAXR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int tick_per = 3;
    int tcnt     = 0;

    int m_cause;
    int m_retry;
    bit m_fs;
    int m_hold;

    function automatic void m_reset();
        m_cause = 0;
        m_retry = 0;
        m_fs    = 1'b0;
        m_hold  = 8;
    endfunction

    function automatic void m_request(input bit w);
        if (w) begin
            m_cause = 1;
            if (m_retry < 3) m_retry = m_retry + 1;
            if (m_retry >= MAXR) m_fs = 1'b1;
        end else begin
            m_cause = 2;
        end
    endfunction

    function automatic logic [7:0] exp_status(input bit busy);
        logic [1:0] r;
        logic [1:0] c;
        r = m_retry[1:0];
        c = m_cause[1:0];
        return {busy, 2'b00, m_fs, r, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.wdt_timeout = 1'b0;
        bus.csr_we      = 1'b0;
        bus.csr_di      = 8'h00;
        bus.boot_done   = 1'b0;
        tcnt++;
        if (tcnt >= tick_per) begin
            tcnt        = 0;
            bus.tick_ce = 1'b1;
        end else begin
            bus.tick_ce = 1'b0;
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        bus.csr_a = a;
        #1;
        d = bus.csr_do;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        bus.csr_a  = a;
        bus.csr_di = d;
        bus.csr_we = 1'b1;
        step();
    endtask

    // One full reset sequence from IDLE, checked tick by tick.
    task automatic run_seq(input string tag, input bit w,
                           input logic [7:0] ctrl, input int hold,
                           input bit inj_assert, input bit inj_blank);
        logic [7:0] d;
        int n;
        int m;
        bit bad;
        if (w) bus.wdt_timeout = 1'b1;
        if (ctrl != 8'h00) begin
            bus.csr_a  = BASE;
            bus.csr_di = ctrl;
            bus.csr_we = 1'b1;
        end
        step();
        m_request(w);
        chk({tag, ".rst_on"}, 32'(bus.board_rst), 32'd1);
        chk({tag, ".fs_pin"}, 32'(bus.failsafe), 32'(m_fs));
        rd(BASE + 5'd1, d);
        chk({tag, ".status_assert"}, 32'(d), 32'(exp_status(1'b1)));
        if (inj_assert) begin
            bus.wdt_timeout = 1'b1;
            bus.csr_a       = BASE;
            bus.csr_di      = 8'h01;
            bus.csr_we      = 1'b1;
        end
        n = 0;
        for (int k = 0; k < 3000; k++) begin
            if (bus.tick_ce) n++;
            step();
            if (!bus.board_rst) break;
        end
        chk({tag, ".rst_off"}, 32'(bus.board_rst), 32'd0);
        chk({tag, ".hold_len"}, 32'(n >= hold - 1 && n <= hold + 1), 32'd1);
        if (inj_blank) bus.wdt_timeout = 1'b1;
        m   = 0;
        bad = 1'b0;
        d   = 8'hff;
        for (int k = 0; k < 3000; k++) begin
            if (bus.tick_ce) m++;
            step();
            if (bus.board_rst) bad = 1'b1;
            rd(BASE + 5'd1, d);
            if (!d[7]) break;
        end
        chk({tag, ".blank_len"}, 32'(m >= BLANK && m <= BLANK + 1), 32'd1);
        chk({tag, ".blank_quiet"}, 32'(bad), 32'd0);
        chk({tag, ".status_idle"}, 32'(d), 32'(exp_status(1'b0)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        int h;
        int src;
        bus.csr_a       = 5'h0;
        bus.csr_di      = 8'h00;
        bus.csr_we      = 1'b0;
        bus.tick_ce     = 1'b0;
        bus.wdt_timeout = 1'b0;
        bus.boot_done   = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        m_reset();

        chk("reset.board_rst", 32'(bus.board_rst), 32'd0);
        chk("reset.failsafe", 32'(bus.failsafe), 32'd0);
        rd(BASE + 5'd1, d);
        chk("reset.status", 32'(d), 32'h00);
        rd(BASE + 5'd2, d);
        chk("reset.hold", 32'(d), 32'h08);
        rd(BASE + 5'd3, d);
        step();
        chk("reset.out_of_range", 32'(d), 32'h00);
        rd(BASE, d);
        chk("reset.ctrl_reads0", 32'(d), 32'h00);
        rd(5'h03, d);
        chk("reset.below_base", 32'(d), 32'h00);

        wr(BASE + 5'd2, 8'd4);
        m_hold = 4;
        rd(BASE + 5'd2, d);
        chk("hold.readback", 32'(d), 32'd4);
        run_seq("wdt1", 1'b1, 8'h00, 4, 1'b0, 1'b0);

        bus.boot_done = 1'b1;
        step();
        m_retry = 0;
        rd(BASE + 5'd1, d);
        chk("boot_done.clear", 32'(d), 32'(exp_status(1'b0)));

        run_seq("soft", 1'b0, 8'h01, 4, 1'b1, 1'b0);

        wr(BASE, 8'h02);
        m_cause = 0;
        rd(BASE + 5'd1, d);
        chk("ctrl.clear_cause", 32'(d), 32'(exp_status(1'b0)));

        for (int i = 0; i < 3; i++) begin
            run_seq($sformatf("wdt_chain%0d", i), 1'b1, 8'h00, 4, 1'b0, 1'b0);
        end
        chk("chain.failsafe", 32'(bus.failsafe), 32'd1);
        wr(BASE, 8'h04);
        m_fs    = 1'b0;
        m_retry = 0;
        rd(BASE + 5'd1, d);
        chk("ctrl.clear_fs", 32'(d), 32'(exp_status(1'b0)));
        chk("ctrl.fs_pin", 32'(bus.failsafe), 32'd0);

        wr(BASE + 5'd2, 8'd2);
        m_hold = 2;
        run_seq("both", 1'b1, 8'h01, 2, 1'b0, 1'b1);

        wr(BASE + 5'd2, 8'd0);
        m_hold = 0;
        run_seq("hold0", 1'b0, 8'h03, 1, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            h        = int'($urandom_range(0, 6));
            tick_per = int'($urandom_range(2, 5));
            wr(BASE + 5'd2, 8'(h));
            m_hold = h;
            if ($urandom_range(0, 2) == 0) begin
                bus.boot_done = 1'b1;
                step();
                m_retry = 0;
            end
            if ($urandom_range(0, 4) == 0) begin
                wr(BASE, 8'h04);
                m_fs    = 1'b0;
                m_retry = 0;
            end
            src = int'($urandom_range(1, 3));
            run_seq($sformatf("rand%0d", i), src[0],
                    src[1] ? 8'h01 : 8'h00, (h == 0) ? 1 : h,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        tick_per = 3;
        wr(BASE + 5'd2, 8'd6);
        bus.wdt_timeout = 1'b1;
        step();
        repeat (4) step();
        chk("midrst.asserted", 32'(bus.board_rst), 32'd1);
        rst = 1'b1;
        step();
        chk("midrst.board_rst", 32'(bus.board_rst), 32'd0);
        rst = 1'b0;
        m_reset();
        rd(BASE + 5'd1, d);
        chk("midrst.status", 32'(d), 32'h00);
        rd(BASE + 5'd2, d);
        chk("midrst.hold", 32'(d), 32'(m_hold));
        step();
        chk("midrst.fs_pin", 32'(bus.failsafe), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
